// File: rtl/prv32_muldiv_unit.sv
// prv32_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: trivial ops skip the iteration loop.
module prv32_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            busy
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   ma_q, ma_d;
  logic [XLEN-1:0]   mb_q, mb_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic              early_q, early_d;
  logic [XLEN-1:0]   r_q, r_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              hit;
  logic [XLEN-1:0]   hit_res;
  logic [XLEN:0]     sum, diff;
  logic [W2-1:0]     step_mul, step_div, prod;
  logic [XLEN-1:0]   quo, rem, res_fix;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign r         = r_q;

  // Operand signedness, magnitudes and trivial-case detection
  always_comb begin
    a_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_sgn   = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    a_neg   = a_sgn & a[XLEN-1];
    b_neg   = b_sgn & b[XLEN-1];
    abs_a   = a_neg ? -a : a;
    abs_b   = b_neg ? -b : b;
    hit     = 1'b0;
    hit_res = '0;
`ifdef MDU_EARLY_OUT_EN
    if (!op[2]) begin
      if (a == '0 || b == '0) begin
        hit     = 1'b1;
        hit_res = '0;
      end
    end else if (b == '0) begin
      hit     = 1'b1;
      hit_res = op[1] ? a : '1;
    end else if (!op[0] && a == SMIN && b == '1) begin
      hit     = 1'b1;
      hit_res = op[1] ? '0 : SMIN;
    end
`endif
  end

  // One shift-add / restoring-subtract step and final sign fixup
  always_comb begin
    sum      = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    step_mul = {sum, acc_q[XLEN-1:1]};
    diff     = acc_q[W2-1:XLEN-1] - {1'b0, mb_q};
    step_div = diff[XLEN] ? {acc_q[W2-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = negr_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    res_fix  = '0;
    unique case (op_q)
      3'b000:                 res_fix = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fix = prod[W2-1:XLEN];
      3'b100, 3'b101:         res_fix = quo;
      default:                res_fix = rem;
    endcase
  end

  // FSM next state and datapath updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    early_d = early_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          ma_d    = abs_a;
          mb_d    = abs_b;
          acc_d   = op[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
          cnt_d   = CNT_INIT;
          neg_d   = (a_neg ^ b_neg) & (~op[2] | (b != '0));
          negr_d  = a_neg;
          early_d = hit;
          if (hit) begin
            r_d     = hit_res;
            state_d = FIXUP;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? step_div : step_mul;
        if (cnt_q == '0) state_d = FIXUP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIXUP: begin
        if (!early_q) r_d = res_fix;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
    if (flush) state_d = IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      early_q <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      early_q <= early_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_prv32_muldiv_unit.sv
// tb_prv32_muldiv_unit: directed vectors for the iterative mul/div unit.
// Boundary-case latency follows MDU_EARLY_OUT_EN when defined.
module tb_prv32_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] r;
  logic        busy;

  int tests = 0;
  int fails = 0;

  localparam int NL = 33;
`ifdef MDU_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif

  prv32_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = aa;
    b = bb;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    start_op(o, aa, bb);
    wait_valid(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " r"}, r, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " in_ready_next"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    #1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst r", r, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, NL);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NL);
    run_op("mulh min*min", 3'b001, 32'h80000000, 32'h80000000,
           32'h40000000, NL);
    run_op("mulhsu -1*2", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, NL);
    run_op("mulh -3*5", 3'b001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, NL);
    run_op("mul 0*5", 3'b000, 32'd0, 32'd5, 32'd0, EL);
    run_op("div -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, NL);
    run_op("rem -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, NL);
    run_op("divu min/3", 3'b101, 32'h80000000, 32'd3, 32'h2AAAAAAA, NL);
    run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, NL);
    run_op("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, EL);
    run_op("div -5/0", 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EL);
    run_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, EL);
    run_op("rem -5/0", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, EL);
    run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, EL);
    run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, EL);

    // hold result with out_ready low
    start_op(3'b000, 32'd6, 32'd7);
    wait_valid(lat);
    chk("hold latency", lat, NL);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold r", r, 32'd42);
      chk("hold out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold release in_ready", {31'b0, in_ready}, 32'd1);

    // flush with in_valid in IDLE is not accepted
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    op = 3'b101;
    a = 32'd9;
    b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush busy", {31'b0, busy}, 32'd0);
    chk("idle flush in_ready", {31'b0, in_ready}, 32'd1);

    // flush at CALC iteration 12
    start_op(3'b101, 32'd1000, 32'd7);
    repeat (12) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("flush no out_valid", seen, 32'd0);
    chk("flush idle", {31'b0, in_ready}, 32'd1);

    // async reset mid-CALC
    start_op(3'b000, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst busy", {31'b0, busy}, 32'd0);
    chk("arst r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("arst no out_valid", seen, 32'd0);

    run_op("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, NL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
